// File: rtl/mmw_pkg.sv
`default_nettype none
// mmw_pkg: FSM state encoding and one-hot relation codes for the min/max window tracker.
// Revision 1.0
package mmw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] REL_LT = 3'b100;
  localparam logic [2:0] REL_EQ = 3'b010;
  localparam logic [2:0] REL_GT = 3'b001;

endpackage
`default_nettype wire

// File: rtl/cmp_rel_core.sv
`default_nettype none
// cmp_rel_core: combinational one-hot relation of a versus b, signed or unsigned order.
// Revision 1.0
import mmw_pkg::*;

module cmp_rel_core #(
  parameter int WIDTH = 3
) (
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       rel
);

  logic [WIDTH-1:0] sign_flip;
  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;

  // Flipping the MSB maps two's-complement order onto plain unsigned order.
  assign sign_flip = WIDTH'(signed_mode) << (WIDTH - 1);
  assign a_key     = a ^ sign_flip;
  assign b_key     = b ^ sign_flip;

  always_comb begin
    rel = REL_EQ;
    if (a_key < b_key) begin
      rel = REL_LT;
    end else if (a_key > b_key) begin
      rel = REL_GT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/minmax_window_tracker.sv
`default_nettype none
// minmax_window_tracker: running max/min over a window of samples, plus last-vs-first relation.
// Revision 1.0
import mmw_pkg::*;

module minmax_window_tracker #(
  parameter int WIDTH  = 3,
  parameter int WINDOW = 8,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             signed_mode,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [2:0]       out_rel
);

  localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] first_val;
  logic             mode_lat;
  logic [2:0]       rel_val;
  logic [2:0]       rel_max;
  logic [2:0]       rel_min;
  logic [2:0]       rel_first;
  logic             accept;
  logic             last_accept;

  assign in_ready    = (state != DONE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid & in_ready;
  assign cnt_inc     = cnt + CNT_W'(1);
  assign last_accept = accept & (state == ACC) & (cnt_inc == WIN_CNT);

  assign out_max = max_val;
  assign out_min = min_val;
  assign out_rel = rel_val;

  cmp_rel_core #(.WIDTH(WIDTH)) u_cmp_max (
    .signed_mode (mode_lat),
    .a           (in_data),
    .b           (max_val),
    .rel         (rel_max)
  );

  cmp_rel_core #(.WIDTH(WIDTH)) u_cmp_min (
    .signed_mode (mode_lat),
    .a           (in_data),
    .b           (min_val),
    .rel         (rel_min)
  );

  cmp_rel_core #(.WIDTH(WIDTH)) u_cmp_first (
    .signed_mode (mode_lat),
    .a           (in_data),
    .b           (first_val),
    .rel         (rel_first)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = (WINDOW == 1) ? DONE : ACC;
        ACC:     if (last_accept) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      max_val   <= '0;
      min_val   <= '0;
      first_val <= '0;
      mode_lat  <= 1'b0;
      rel_val   <= 3'b000;
    end else if (clear) begin
      cnt       <= '0;
      max_val   <= '0;
      min_val   <= '0;
      first_val <= '0;
      mode_lat  <= 1'b0;
      rel_val   <= 3'b000;
    end else if (accept) begin
      if (state == IDLE) begin
        first_val <= in_data;
        max_val   <= in_data;
        min_val   <= in_data;
        mode_lat  <= signed_mode;
        cnt       <= CNT_W'(1);
        rel_val   <= REL_EQ;
      end else begin
        // Strict comparisons only, so ties keep the earlier sample.
        if (rel_max == REL_GT) max_val <= in_data;
        if (rel_min == REL_LT) min_val <= in_data;
        cnt     <= cnt_inc;
        rel_val <= rel_first;
      end
    end
  end

endmodule
`default_nettype wire
